// File: rtl/slice_seq_pkg.sv
// Shared types and default pipeline latencies for the slice phase sequencer.
package slice_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam int unsigned DCT_LAT         = 10;
    localparam int unsigned DC_VLC_LAT      = 44;
    localparam int unsigned DC_EN_DLY       = 7;
    localparam int unsigned AC_EN_DLY       = 6;
    localparam int unsigned AC_COEF_PER_BLK = 63;

endpackage

// File: rtl/sps_window_gen.sv
// Registered inclusive window detector: level is high when run && lo <= c <= hi.
module sps_window_gen #(
    parameter int unsigned W = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         run_i,
    input  logic [W-1:0] c_i,
    input  logic [W-1:0] lo_i,
    input  logic [W-1:0] hi_i,
    output logic         level_o
);

    logic level_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= run_i && (c_i >= lo_i) && (c_i <= hi_i);
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/slice_phase_sequencer.sv
// Start-triggered slice sequencer: runs NUM_CH channel passes and derives the DC/AC VLC
// reset, enable and flush windows from the latched block count.
module slice_phase_sequencer #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MAX_BLOCKS = 32,
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned DCT_LAT    = slice_seq_pkg::DCT_LAT,
    parameter int unsigned DC_VLC_LAT = slice_seq_pkg::DC_VLC_LAT,
    parameter int unsigned DC_EN_DLY  = slice_seq_pkg::DC_EN_DLY,
    parameter int unsigned AC_EN_DLY  = slice_seq_pkg::AC_EN_DLY
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [CNT_W-1:0]          block_num_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [$clog2(NUM_CH):0]   ch_idx_o,
    output logic [CNT_W-1:0]          seq_cnt_o,
    output logic                      dc_vlc_reset_o,
    output logic                      dc_vlc_output_enable_o,
    output logic [CNT_W-1:0]          dc_vlc_counter_o,
    output logic                      ac_vlc_reset_o,
    output logic                      ac_vlc_output_enable_o,
    output logic                      ac_vlc_output_flush_o,
    output logic [CNT_W-1:0]          ac_vlc_counter_o
);

    import slice_seq_pkg::*;

    localparam int unsigned CH_W = $clog2(NUM_CH) + 1;
    localparam longint unsigned MaxEnd = 64'(DCT_LAT) + 64'(MAX_BLOCKS) + 64'(DC_VLC_LAT)
                                       + 64'(AC_COEF_PER_BLK) * 64'(MAX_BLOCKS) + 64'd8;

    if ((MaxEnd >> CNT_W) != 0) begin : g_cnt_w_too_small
        $error("CNT_W cannot hold the pass end count for MAX_BLOCKS");
    end
    if (NUM_CH == 0) begin : g_num_ch_zero
        $error("NUM_CH must be at least 1");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] c_q, c_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             busy_q, done_q;
    logic             run_d;
    logic [CNT_W-1:0] dc_cnt_q, dc_cnt_d;
    logic [CNT_W-1:0] ac_cnt_q, ac_cnt_d;

    // Window bounds follow the next-cycle block count so the registered windows line up with c.
    logic [CNT_W-1:0] dc_start, ac_start, ac_stop, pass_end;
    logic [CNT_W-1:0] dc_rst_lo, dc_rst_hi, dc_oe_lo, dc_oe_hi;
    logic [CNT_W-1:0] ac_rst_lo, ac_rst_hi, ac_oe_lo, ac_oe_hi, flush_at;

    always_comb begin
        dc_start  = CNT_W'(DCT_LAT) + n_d;
        ac_start  = dc_start + CNT_W'(DC_VLC_LAT);
        ac_stop   = ac_start + n_d * CNT_W'(AC_COEF_PER_BLK);
        pass_end  = ac_stop + CNT_W'(8);
        dc_rst_lo = dc_start + CNT_W'(1);
        dc_rst_hi = dc_start + n_d + CNT_W'(7);
        dc_oe_lo  = dc_start + CNT_W'(DC_EN_DLY);
        dc_oe_hi  = dc_start + n_d + CNT_W'(DC_EN_DLY) - CNT_W'(1);
        ac_rst_lo = ac_start + CNT_W'(1);
        ac_rst_hi = ac_stop + CNT_W'(7);
        ac_oe_lo  = ac_start + CNT_W'(AC_EN_DLY);
        ac_oe_hi  = ac_stop + CNT_W'(AC_EN_DLY) - CNT_W'(1);
        flush_at  = ac_stop + CNT_W'(AC_EN_DLY);
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        n_d     = n_q;
        ch_d    = ch_q;
        pend_d  = 1'b0;
        err_d   = 1'b0;
        if (abort_i) begin
            state_d = StIdle;
            c_d     = '0;
            ch_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pend_q) begin
                        state_d = StDone;
                    end else if (start_i) begin
                        if (block_num_i > CNT_W'(MAX_BLOCKS)) begin
                            err_d = 1'b1;
                        end else if (block_num_i == '0) begin
                            // Empty slice: no pass runs, done follows one cycle later.
                            n_d    = '0;
                            pend_d = 1'b1;
                        end else begin
                            state_d = StRun;
                            n_d     = block_num_i;
                            c_d     = '0;
                            ch_d    = '0;
                        end
                    end
                end
                StRun: begin
                    if (c_q == pass_end) begin
                        c_d = '0;
                        if (ch_q == CH_W'(NUM_CH - 1)) begin
                            state_d = StDone;
                            ch_d    = '0;
                        end else begin
                            ch_d = ch_q + CH_W'(1);
                        end
                    end else begin
                        c_d = c_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                    c_d     = '0;
                    ch_d    = '0;
                end
            endcase
        end
        run_d = (state_d == StRun);
        dc_cnt_d = (run_d && c_d >= dc_rst_lo && c_d <= dc_rst_hi) ? c_d - dc_rst_lo : '0;
        ac_cnt_d = (run_d && c_d >= ac_rst_lo && c_d <= ac_rst_hi) ? c_d - ac_rst_lo : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            c_q      <= '0;
            n_q      <= '0;
            ch_q     <= '0;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dc_cnt_q <= '0;
            ac_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            n_q      <= n_d;
            ch_q     <= ch_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            busy_q   <= run_d;
            done_q   <= (state_d == StDone);
            dc_cnt_q <= dc_cnt_d;
            ac_cnt_q <= ac_cnt_d;
        end
    end

    sps_window_gen #(.W(CNT_W)) u_dc_rst (
        .clock   (clock),
        .reset_n (reset_n),
        .run_i   (run_d),
        .c_i     (c_d),
        .lo_i    (dc_rst_lo),
        .hi_i    (dc_rst_hi),
        .level_o (dc_vlc_reset_o)
    );

    sps_window_gen #(.W(CNT_W)) u_dc_oe (
        .clock   (clock),
        .reset_n (reset_n),
        .run_i   (run_d),
        .c_i     (c_d),
        .lo_i    (dc_oe_lo),
        .hi_i    (dc_oe_hi),
        .level_o (dc_vlc_output_enable_o)
    );

    sps_window_gen #(.W(CNT_W)) u_ac_rst (
        .clock   (clock),
        .reset_n (reset_n),
        .run_i   (run_d),
        .c_i     (c_d),
        .lo_i    (ac_rst_lo),
        .hi_i    (ac_rst_hi),
        .level_o (ac_vlc_reset_o)
    );

    sps_window_gen #(.W(CNT_W)) u_ac_oe (
        .clock   (clock),
        .reset_n (reset_n),
        .run_i   (run_d),
        .c_i     (c_d),
        .lo_i    (ac_oe_lo),
        .hi_i    (ac_oe_hi),
        .level_o (ac_vlc_output_enable_o)
    );

    sps_window_gen #(.W(CNT_W)) u_flush (
        .clock   (clock),
        .reset_n (reset_n),
        .run_i   (run_d),
        .c_i     (c_d),
        .lo_i    (flush_at),
        .hi_i    (flush_at),
        .level_o (ac_vlc_output_flush_o)
    );

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign ch_idx_o         = ch_q;
    assign seq_cnt_o        = c_q;
    assign dc_vlc_counter_o = dc_cnt_q;
    assign ac_vlc_counter_o = ac_cnt_q;

endmodule

// File: tb/tb_slice_phase_sequencer.sv
// Directed bench: one single-channel and one three-channel sequencer driven from shared inputs.
module tb_slice_phase_sequencer;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        err;
        logic [2:0]  ch;
        logic [31:0] seq;
        logic        dr;
        logic        doe;
        logic [31:0] dcnt;
        logic        ar;
        logic        aoe;
        logic        fl;
        logic [31:0] acnt;
    } obs_t;

    typedef struct {
        int dlo, dhi, olo, ohi, alo, ahi, aolo, aohi, fl;
    } bnd_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] block_num = '0;

    logic        busy1, done1, err1, dr1, doe1, ar1, aoe1, fl1;
    logic [0:0]  ch1;
    logic [31:0] seq1, dcnt1, acnt1;
    logic        busy3, done3, err3, dr3, doe3, ar3, aoe3, fl3;
    logic [2:0]  ch3;
    logic [31:0] seq3, dcnt3, acnt3;

    obs_t o1, o3;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    slice_phase_sequencer #(.NUM_CH(1)) dut1 (
        .clock                  (clock),
        .reset_n                (reset_n),
        .start_i                (start),
        .abort_i                (abort),
        .block_num_i            (block_num),
        .busy_o                 (busy1),
        .done_o                 (done1),
        .err_o                  (err1),
        .ch_idx_o               (ch1),
        .seq_cnt_o              (seq1),
        .dc_vlc_reset_o         (dr1),
        .dc_vlc_output_enable_o (doe1),
        .dc_vlc_counter_o       (dcnt1),
        .ac_vlc_reset_o         (ar1),
        .ac_vlc_output_enable_o (aoe1),
        .ac_vlc_output_flush_o  (fl1),
        .ac_vlc_counter_o       (acnt1)
    );

    slice_phase_sequencer #(.NUM_CH(3)) dut3 (
        .clock                  (clock),
        .reset_n                (reset_n),
        .start_i                (start),
        .abort_i                (abort),
        .block_num_i            (block_num),
        .busy_o                 (busy3),
        .done_o                 (done3),
        .err_o                  (err3),
        .ch_idx_o               (ch3),
        .seq_cnt_o              (seq3),
        .dc_vlc_reset_o         (dr3),
        .dc_vlc_output_enable_o (doe3),
        .dc_vlc_counter_o       (dcnt3),
        .ac_vlc_reset_o         (ar3),
        .ac_vlc_output_enable_o (aoe3),
        .ac_vlc_output_flush_o  (fl3),
        .ac_vlc_counter_o       (acnt3)
    );

    always_comb begin
        o1.busy = busy1; o1.done = done1; o1.err = err1; o1.ch = {2'b00, ch1};
        o1.seq = seq1; o1.dr = dr1; o1.doe = doe1; o1.dcnt = dcnt1;
        o1.ar = ar1; o1.aoe = aoe1; o1.fl = fl1; o1.acnt = acnt1;
        o3.busy = busy3; o3.done = done3; o3.err = err3; o3.ch = ch3;
        o3.seq = seq3; o3.dr = dr3; o3.doe = doe3; o3.dcnt = dcnt3;
        o3.ar = ar3; o3.aoe = aoe3; o3.fl = fl3; o3.acnt = acnt3;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] n);
        start = 1'b1;
        block_num = n;
        step();
        start = 1'b0;
    endtask

    // Expected pass outputs at cycle c from hand-computed inclusive window bounds.
    task automatic chk_pass(input string who, input obs_t o, input int c, input int ch,
                            input bnd_t b);
        string p;
        bit    dr, ar;
        p  = $sformatf("%s c=%0d ch=%0d", who, c, ch);
        dr = (c >= b.dlo && c <= b.dhi);
        ar = (c >= b.alo && c <= b.ahi);
        chk({p, " seq_cnt"}, o.seq, c);
        chk({p, " ch_idx"}, {29'd0, o.ch}, ch);
        chk({p, " busy"}, {31'd0, o.busy}, 1);
        chk({p, " done"}, {31'd0, o.done}, 0);
        chk({p, " err"}, {31'd0, o.err}, 0);
        chk({p, " dc_rst"}, {31'd0, o.dr}, {31'd0, dr});
        chk({p, " dc_oe"}, {31'd0, o.doe}, (c >= b.olo && c <= b.ohi) ? 1 : 0);
        chk({p, " dc_cnt"}, o.dcnt, dr ? c - b.dlo : 0);
        chk({p, " ac_rst"}, {31'd0, o.ar}, {31'd0, ar});
        chk({p, " ac_oe"}, {31'd0, o.aoe}, (c >= b.aolo && c <= b.aohi) ? 1 : 0);
        chk({p, " ac_cnt"}, o.acnt, ar ? c - b.alo : 0);
        chk({p, " flush"}, {31'd0, o.fl}, (c == b.fl) ? 1 : 0);
    endtask

    task automatic chk_idle(input string who, input obs_t o, input bit done_exp,
                            input bit err_exp);
        chk({who, " busy"}, {31'd0, o.busy}, 0);
        chk({who, " done"}, {31'd0, o.done}, {31'd0, done_exp});
        chk({who, " err"}, {31'd0, o.err}, {31'd0, err_exp});
        chk({who, " ch_idx"}, {29'd0, o.ch}, 0);
        chk({who, " seq_cnt"}, o.seq, 0);
        chk({who, " windows"}, {27'd0, o.dr, o.doe, o.ar, o.aoe, o.fl}, 0);
        chk({who, " dc_cnt"}, o.dcnt, 0);
        chk({who, " ac_cnt"}, o.acnt, 0);
    endtask

    initial begin
        bnd_t b4, b1;
        b4 = '{dlo: 15, dhi: 25, olo: 21, ohi: 24, alo: 59, ahi: 317,
               aolo: 64, aohi: 315, fl: 316};
        b1 = '{dlo: 12, dhi: 19, olo: 18, ohi: 18, alo: 56, ahi: 125,
               aolo: 61, aohi: 123, fl: 124};

        // Reset state
        repeat (3) step();
        chk_idle("rst d1", o1, 0, 0);
        chk_idle("rst d3", o3, 0, 0);
        reset_n = 1'b1;
        step();
        chk_idle("post-rst d1", o1, 0, 0);

        // N=4 pass with an ignored re-start (N=9) at c=100
        pulse_start(32'd4);
        for (int c = 0; c <= 318; c++) begin
            chk_pass("n4 d1", o1, c, 0, b4);
            chk_pass("n4 d3", o3, c, 0, b4);
            if (c == 100) begin
                start = 1'b1;
                block_num = 32'd9;
            end
            step();
            start = 1'b0;
        end
        chk_idle("n4 done d1", o1, 1, 0);
        chk_pass("n4 d3 pass1", o3, 0, 1, b4);
        step();
        chk_idle("n4 after d1", o1, 0, 0);
        chk_pass("n4 d3 pass1", o3, 1, 1, b4);

        // Abort at c=200 of the second pass while ac_oe is high
        for (int c = 2; c <= 200; c++) begin
            step();
            chk_pass("pre-abort d3", o3, c, 1, b4);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle("abort d3", o3, 0, 0);
        chk_idle("abort d1", o1, 0, 0);
        step();
        chk_idle("abort+1 d3", o3, 0, 0);

        // N=1: three back-to-back passes on dut3, single pass on dut1
        pulse_start(32'd1);
        for (int k = 0; k < 381; k++) begin
            chk_pass("n1 d3", o3, k % 127, k / 127, b1);
            if (k < 127) chk_pass("n1 d1", o1, k, 0, b1);
            else if (k == 127) chk_idle("n1 done d1", o1, 1, 0);
            else chk_idle("n1 idle d1", o1, 0, 0);
            step();
        end
        chk_idle("n1 done d3", o3, 1, 0);
        step();
        chk_idle("n1 after d3", o3, 0, 0);

        // Oversized block count
        pulse_start(32'd33);
        chk_idle("n33 err d1", o1, 0, 1);
        chk_idle("n33 err d3", o3, 0, 1);
        step();
        chk_idle("n33 after d1", o1, 0, 0);

        // Empty slice: done two cycles after start, never busy
        pulse_start(32'd0);
        chk_idle("n0 +1 d1", o1, 0, 0);
        chk_idle("n0 +1 d3", o3, 0, 0);
        step();
        chk_idle("n0 +2 d1", o1, 1, 0);
        chk_idle("n0 +2 d3", o3, 1, 0);
        step();
        chk_idle("n0 +3 d1", o1, 0, 0);

        // Abort and start together while idle: start dropped
        abort = 1'b1;
        pulse_start(32'd4);
        abort = 1'b0;
        chk_idle("abort+start d1", o1, 0, 0);
        step();
        chk_idle("abort+start +2 d1", o1, 0, 0);

        // Asynchronous reset mid-pass
        pulse_start(32'd4);
        for (int c = 0; c < 60; c++) begin
            chk_pass("pre-rst d1", o1, c, 0, b4);
            step();
        end
        chk_pass("pre-rst d1", o1, 60, 0, b4);
        #2 reset_n = 1'b0;
        #1;
        chk_idle("async rst d1", o1, 0, 0);
        chk_idle("async rst d3", o3, 0, 0);
        #3 reset_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            chk_idle("rst idle d1", o1, 0, 0);
            chk_idle("rst idle d3", o3, 0, 0);
            step();
        end
        pulse_start(32'd1);
        chk_pass("restart d1", o1, 0, 0, b1);
        step();
        chk_pass("restart d1", o1, 1, 0, b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
